// File: rtl/result_edge_sampler.sv
// Synchronizes io_result into clk, timestamps its rising edges and queues them in a FIFO.
// Define RESULT_EDGE_SAMPLER_DROP_CNT_EN to add the saturating io_dropped counter.
module result_edge_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_result,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [CNT_W-1:0] io_out_bits,
  output logic             io_overflow,
  input  logic             io_ovf_clr
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] io_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TS_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic                   prev;
  logic [CNT_W-1:0]       ts;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            wr_ptr;
  logic [CNT_W-1:0]       mem [DEPTH];

  logic event_det;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    sync_q    = sync[SYNC_STAGES-1];
    event_det = sync_q & ~prev;
    empty     = (rd_ptr == wr_ptr);
    full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    pop       = ~empty & io_out_ready;
    push      = event_det & (~full | pop);
    drop      = event_det & full & ~pop;
  end

  assign io_out_valid = ~empty;
  // Storage is not reset, so the head is masked while nothing is queued.
  assign io_out_bits  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= '0;
      prev        <= 1'b0;
      ts          <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      io_overflow <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], io_result};
      prev <= sync_q;
      ts   <= ts + TS_ONE;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)            io_overflow <= 1'b1;
      else if (io_ovf_clr) io_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr[AW-1:0]] <= ts;
  end

`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_dropped <= '0;
    end else if (drop) begin
      if (io_ovf_clr)           io_dropped <= TS_ONE;
      else if (io_dropped != '1) io_dropped <= io_dropped + TS_ONE;
    end else if (io_ovf_clr) begin
      io_dropped <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_result_edge_sampler.sv
// Scoreboard bench for result_edge_sampler: directed scenarios plus randomized traffic
// against a sample-history reference model.
module tb_result_edge_sampler;

  localparam int S     = 2;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int MODV  = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_result = 1'b0;
  logic         io_out_ready = 1'b0;
  logic         io_ovf_clr = 1'b0;
  logic         io_out_valid;
  logic [W-1:0] io_out_bits;
  logic         io_overflow;
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
  logic [W-1:0] io_dropped;
`endif

  result_edge_sampler #(.SYNC_STAGES(S), .CNT_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .io_result(io_result),
    .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid),
    .io_out_bits(io_out_bits),
    .io_overflow(io_overflow),
    .io_ovf_clr(io_ovf_clr)
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
    ,
    .io_dropped(io_dropped)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an event happens in cycle c when the input sampled at the end
  // of cycle c-S was high and the one sampled at the end of cycle c-S-1 was low.
  bit started = 0;
  int hist[$];       // hist[i] = input sampled at end of cycle (c-1-i)
  int exp_q[$];      // accepted timestamps, oldest first
  int occ;
  int tsm;
  bit ovf_m;
  int drop_m;

  always @(posedge clk) begin
    bit ev, pop, drop;
    if (reset) begin
      started = 1;
      occ = 0; tsm = 0; ovf_m = 0; drop_m = 0;
      exp_q.delete();
      hist.delete();
      repeat (S + 1) hist.push_back(0);
    end else if (started) begin
      ev   = (hist[S-1] == 1) && (hist[S] == 0);
      pop  = (occ > 0) && io_out_ready;
      drop = 0;
      if (ev) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back(tsm);
          occ++;
        end else drop = 1;
      end
      if (pop) occ--;
      if (drop) ovf_m = 1;
      else if (io_ovf_clr) ovf_m = 0;
      if (drop) drop_m = io_ovf_clr ? 1 : ((drop_m < MODV - 1) ? drop_m + 1 : drop_m);
      else if (io_ovf_clr) drop_m = 0;
      hist.push_front(int'(io_result));
      void'(hist.pop_back());
      tsm = (tsm + 1) % MODV;
    end
  end

  // Flag/occupancy checks against the model state for the current cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("valid", {31'd0, io_out_valid}, {31'd0, occ > 0});
      chk("overflow", {31'd0, io_overflow}, {31'd0, ovf_m});
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
      chk("dropped", {24'd0, io_dropped}, drop_m);
`endif
    end
  end

  // Monitor: every handshake pops the scoreboard and compares the head.
  always @(negedge clk) begin
    if (started && !reset) begin
      if (io_out_valid === 1'b1 && io_out_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_bits", {24'd0, io_out_bits}, exp_q.pop_front());
      end else if (io_out_valid === 1'b0) begin
        chk("bits_masked", {24'd0, io_out_bits}, 0);
      end
    end
  end

  task automatic drive(input bit r, input bit rdy, input bit clr);
    @(posedge clk);
    #1;
    io_result = r; io_out_ready = rdy; io_ovf_clr = clr;
  endtask

  task automatic pulse(input bit rdy);
    drive(1, rdy, 0); drive(1, rdy, 0); drive(0, rdy, 0); drive(0, rdy, 0);
  endtask

  task automatic do_reset(input bit r);
    @(posedge clk);
    #1;
    reset = 1; io_result = r; io_out_ready = 0; io_ovf_clr = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) drive(0, 1, 0);
    @(negedge clk);
    chk("drained", {31'd0, io_out_valid}, 0);
  endtask

  int fs;
  int guard;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;                                   // cycle 0

    // Single event sampled at cycle 10, then falling edge ignored.
    repeat (9) drive(0, 0, 0);                   // cycles 1..9
    repeat (3) drive(1, 0, 0);                   // 10..12
    @(negedge clk);
    chk("single_not_yet", {31'd0, io_out_valid}, 0);
    drive(1, 1, 0);                              // 13
    @(negedge clk);
    chk("single_valid", {31'd0, io_out_valid}, 1);
    chk("single_bits", {24'd0, io_out_bits}, 12);
    drive(1, 0, 0);                              // 14
    @(negedge clk);
    chk("single_popped", {31'd0, io_out_valid}, 0);
    repeat (6) drive(1, 1, 0);                   // 15..20
    repeat (6) drive(0, 1, 0);
    @(negedge clk);
    chk("fall_ignored", {31'd0, io_out_valid}, 0);

    // Fill and drop.
    fs = (tsm + 1 + S) % MODV;
    repeat (5) pulse(0);
    repeat (2) drive(0, 0, 0);
    @(negedge clk);
    chk("fill_overflow", {31'd0, io_overflow}, 1);
    chk("fill_head", {24'd0, io_out_bits}, fs);
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
    chk("fill_dropped", {24'd0, io_dropped}, 1);
`endif
    drive(0, 0, 1);
    drive(0, 0, 0);
    @(negedge clk);
    chk("clear_alone", {31'd0, io_overflow}, 0);

    // Full with a pop coinciding with the event.
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    @(negedge clk);
    chk("full_pop_no_ovf", {31'd0, io_overflow}, 0);
    drain();

    // Timestamp wrap: events at ts 255 and 3.
    guard = 0;
    while (tsm != 252 && guard < 600) begin
      drive(0, 1, 0);
      guard++;
    end
    chk("wrap_reach", {31'd0, guard < 600}, 1);
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    @(negedge clk);
    chk("wrap_head", {24'd0, io_out_bits}, 255);

    // Drop together with clear: set wins.
    repeat (2) pulse(0);
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 1); drive(0, 0, 0);
    @(negedge clk);
    chk("drop_clr_ovf", {31'd0, io_overflow}, 1);
`ifdef RESULT_EDGE_SAMPLER_DROP_CNT_EN
    chk("drop_clr_cnt", {24'd0, io_dropped}, 1);
`endif
    drive(0, 0, 1);
    drive(0, 0, 0);
    @(negedge clk);
    chk("late_clear", {31'd0, io_overflow}, 0);
    drain();

    // Reset mid-operation with io_result held high.
    repeat (3) pulse(0);
    drive(1, 0, 0);
    do_reset(1);                                 // now cycle 0
    @(negedge clk);
    chk("rst_valid", {31'd0, io_out_valid}, 0);
    chk("rst_ovf", {31'd0, io_overflow}, 0);
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);   // 1..3
    @(negedge clk);
    chk("rst_event_valid", {31'd0, io_out_valid}, 1);
    chk("rst_event_bits", {24'd0, io_out_bits}, 2);
    repeat (6) drive(1, 1, 0);
    @(negedge clk);
    chk("rst_one_entry", {31'd0, io_out_valid}, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        drive(($urandom_range(0, 2) == 0) ? ~io_result : io_result,
              $urandom_range(0, 3) != 0 && (i % 200) < 150,
              $urandom_range(0, 15) == 0);
      end
    end
    drive(0, 0, 0);
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_edge_sampler.md
# result_edge_sampler

Downstream consumer of the gated-clock sub-component's `io_result` level. It brings that level into the main `clk` domain through a synchronizer and detects rising edges. Each edge is timestamped with a free-running cycle counter and queued in a small FIFO, which is drained over a ready/valid port. Overflow is reported with a sticky flag.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count, legal range 2..4.
- `CNT_W`, default 8: timestamp width.
- `DEPTH`, default 4: FIFO entries, power of two, at least 2.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high; sampled on `posedge clk`.
- `io_result`  in  1  asynchronous level from the gated-clock domain.
- `io_out_ready`  in  1  consumer ready.
- `io_out_valid`  out  1  FIFO non-empty.
- `io_out_bits`  out  CNT_W  timestamp at FIFO head.
- `io_overflow`  out  1  sticky; set when an event is dropped.
- `io_ovf_clr`  in  1  clears `io_overflow`.
- `io_dropped`  out  CNT_W  dropped-event count. Present only with the macro; see Configuration.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops, `sync[0]` samples `io_result`. No logic between stages. `sync_q` is the last stage.
- **Edge detect:** `prev` holds last cycle's `sync_q`. Event = `sync_q & ~prev`. Falling edges are ignored.
- **Timestamp counter `ts`:**
  - increments every cycle while not in reset;
  - wraps from 2^CNT_W−1 to 0;
  - the event's timestamp is the `ts` value in the event cycle.
- **FIFO:** DEPTH entries, CNT_W wide, registered storage. `rd_ptr`/`wr_ptr` have log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - push = event & (~full | pop);
  - pop = `io_out_valid & io_out_ready`.
- **Simultaneous push and pop:**
  - when full, the push is accepted and occupancy is unchanged;
  - when empty, the pushed entry is not visible until the next cycle, so no bypass.
- **Drop:** event & full & ~pop.
  - Sets `io_overflow`.
  - Increments `io_dropped`, saturating at 2^CNT_W−1 (macro only).
- **`io_overflow` priority:** `io_ovf_clr` clears it. If a drop occurs in the same cycle, set wins and the flag stays 1.
- **Reset:**
  - sync chain, `prev`, `ts`, pointers, `io_overflow` and `io_dropped` all go to 0;
  - `io_out_valid`=0, `io_out_bits`=0;
  - FIFO contents are not reset; `io_out_bits` is masked to 0 while empty;
  - a reset asserted mid-operation discards all queued entries on the next edge;
  - if `io_result` is held high across reset release, one event is generated after synchronization.

## Timing
- Cycle 0 is the first cycle with `reset` low; `ts`=0 in cycle 0.
- **Latency:** `io_result` first sampled high at the edge ending cycle k gives:
  - event in cycle k+SYNC_STAGES;
  - `io_out_valid`=1 from cycle k+SYNC_STAGES+1;
  - `io_out_bits` = (k+SYNC_STAGES) mod 2^CNT_W.
- **Minimum input pulse:** the input must stay high for one full `clk` period and then low for one full `clk` period for the edge to be guaranteed. Narrower pulses may be missed; this is not an error.
- **Throughput:** one event per cycle max, one pop per cycle.
- **Output stability:** `io_out_bits` holds while `io_out_valid & ~io_out_ready`.
- `io_out_valid` does not depend combinationally on `io_out_ready`.
- All outputs are registered or are decodes of registers only; no input-to-output combinational path.

## Configuration
- `RESULT_EDGE_SAMPLER_DROP_CNT_EN`
  - **Defined:** `io_dropped` port and saturating counter exist; `io_ovf_clr` also clears the counter, with drop winning in the same cycle, leaving it at 1.
  - **Undefined:** port and counter are absent; `io_overflow` behaviour is unchanged.

## Test plan
All scenarios use default parameters.
- **Single event:** reset, then `io_result` 0→1 first sampled at cycle 10 → `io_out_valid` rises in cycle 13 with `io_out_bits`=12; pop in cycle 13 → valid=0 in cycle 14.
- **Falling edges ignored:** pulse high for cycles 10..20 with `io_out_ready`=1 → exactly one entry, value 12; the falling edge produces nothing.
- **Fill and drop:** `io_out_ready`=0, five separated rising edges → FIFO holds the first 4 timestamps in order; 5th dropped; `io_overflow`=1; `io_dropped`=1 (macro).
- **Full with simultaneous pop:** FIFO full, event coincides with `io_out_ready`=1 → no drop; head advances; new timestamp becomes the tail; `io_overflow` stays 0.
- **Wrap and clear:** event at `ts`=255 then event at `ts`=3 → entries 255, 3. Pulse `io_ovf_clr` in the same cycle as a drop → `io_overflow` remains 1; clear alone on a later cycle → 0.
- **Reset mid-operation:** 3 entries queued, assert `reset` for 1 cycle → valid=0, overflow=0, `ts` restarts at 0. `io_result` held high through reset → exactly one new entry, value 2.
